// File: rtl/gpu_ctrl_regs.sv
// GPU control register block: channel start control, event status with
// write-one-to-clear, interrupt enables, scratch register and per-channel
// saturating event counters, behind a stall-free request/response bus.
module gpu_ctrl_regs #(
   parameter int unsigned N_CH        = 4,
   parameter bit          START_PULSE = 1'b0
) (
   input  logic            clk_i,
   input  logic            rst_i,
   // request side (regs_req bundle)
   input  logic            regs_req_i,
   input  logic            regs_we_i,
   input  logic [3:0]      regs_be_i,
   input  logic [31:0]     regs_addr_i,
   input  logic [31:0]     regs_wdata_i,
   output logic            regs_gnt_o,
   // response side (regs_rsp bundle)
   output logic            regs_rvalid_o,
   output logic [31:0]     regs_rdata_o,
   // channel side
   input  logic [N_CH-1:0] int_event_i,
   output logic [N_CH-1:0] start_o,
   output logic            interrupt_o
);

   localparam logic [3:0]  A_CTRL    = 4'h0;
   localparam logic [3:0]  A_STATUS  = 4'h1;
   localparam logic [3:0]  A_IRQ_EN  = 4'h2;
   localparam logic [3:0]  A_SCRATCH = 4'h3;
   localparam int unsigned A_CNT0    = 8;
   localparam int unsigned PADW      = 32 - N_CH;

   logic [N_CH-1:0] ctrl_q,    ctrl_d;
   logic [N_CH-1:0] status_q,  status_d;
   logic [N_CH-1:0] irq_en_q,  irq_en_d;
   logic [31:0]     scratch_q, scratch_d;
   logic [15:0]     cnt_q [N_CH];
   logic [15:0]     cnt_d [N_CH];
   logic [N_CH-1:0] evt_hist_q;
   logic            rvalid_q;
   logic [31:0]     rdata_q,   rdata_d;

   logic [3:0]      word;
   logic            acc;
   logic            wr;
   logic [N_CH-1:0] rise;
   logic [31:0]     rd_val;
   logic            unused_addr;

   assign word        = regs_addr_i[5:2];
   assign unused_addr = ^{regs_addr_i[31:6], regs_addr_i[1:0]};
   assign regs_gnt_o  = regs_req_i;
   assign acc         = regs_req_i;
   assign wr          = acc & regs_we_i;
   assign rise        = int_event_i & ~evt_hist_q;

   // Read multiplexer: value of the addressed register before any write.
   always_comb begin
      rd_val = '0;
      case (word)
         A_CTRL:    rd_val = {{PADW{1'b0}}, ctrl_q};
         A_STATUS:  rd_val = {{PADW{1'b0}}, status_q};
         A_IRQ_EN:  rd_val = {{PADW{1'b0}}, irq_en_q};
         A_SCRATCH: rd_val = scratch_q;
         default: begin
            for (int unsigned c = 0; c < N_CH; c++) begin
               if (word == 4'(A_CNT0 + c)) rd_val = {16'h0000, cnt_q[c]};
            end
         end
      endcase
   end

   // Response data: only reads return data, everything else returns zero.
   always_comb begin
      rdata_d = '0;
      if (acc && !regs_we_i) rdata_d = rd_val;
   end

   // Next-state for CTRL, STATUS and IRQ_EN (bit c lives in byte lane c/8).
   always_comb begin
      // In pulse mode any bit set on the last edge drops unless rewritten now.
      ctrl_d   = START_PULSE ? '0 : ctrl_q;
      status_d = status_q;
      irq_en_d = irq_en_q;
      for (int unsigned c = 0; c < N_CH; c++) begin
         if (wr && regs_be_i[c/8]) begin
            if (word == A_CTRL)   ctrl_d[c]   = regs_wdata_i[c];
            if (word == A_IRQ_EN) irq_en_d[c] = regs_wdata_i[c];
            if (word == A_STATUS && regs_wdata_i[c]) status_d[c] = 1'b0;
         end
      end
      // A new event overrides a simultaneous write-one-to-clear.
      status_d = status_d | rise;
   end

   // Next-state for SCRATCH, written per byte lane.
   always_comb begin
      scratch_d = scratch_q;
      for (int unsigned b = 0; b < 4; b++) begin
         if (wr && word == A_SCRATCH && regs_be_i[b])
            scratch_d[8*b +: 8] = regs_wdata_i[8*b +: 8];
      end
   end

   // Next-state for event counters: clear-write wins over increment, saturate at max.
   always_comb begin
      for (int unsigned c = 0; c < N_CH; c++) begin
         cnt_d[c] = cnt_q[c];
         if (wr && (regs_be_i != 4'b0000) && word == 4'(A_CNT0 + c))
            cnt_d[c] = '0;
         else if (rise[c] && (cnt_q[c] != 16'hFFFF))
            cnt_d[c] = cnt_q[c] + 16'd1;
      end
   end

   // State registers; reset also drops any transfer accepted during it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ctrl_q     <= '0;
         status_q   <= '0;
         irq_en_q   <= '0;
         scratch_q  <= '0;
         evt_hist_q <= '0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         for (int unsigned c = 0; c < N_CH; c++) cnt_q[c] <= '0;
      end else begin
         ctrl_q     <= ctrl_d;
         status_q   <= status_d;
         irq_en_q   <= irq_en_d;
         scratch_q  <= scratch_d;
         evt_hist_q <= int_event_i;
         rvalid_q   <= acc;
         rdata_q    <= rdata_d;
         for (int unsigned c = 0; c < N_CH; c++) cnt_q[c] <= cnt_d[c];
      end
   end

   assign regs_rvalid_o = rvalid_q;
   assign regs_rdata_o  = rdata_q;
   assign start_o       = ctrl_q;
   assign interrupt_o   = |(status_q & irq_en_q);

endmodule

// File: tb/tb_gpu_ctrl_regs.sv
// Self-checking bench for gpu_ctrl_regs: a level-mode and a pulse-mode
// instance share stimulus; expectations come from a register-level model.
module tb_gpu_ctrl_regs;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        we  = 1'b0;
   logic [3:0]  be  = '0;
   logic [31:0] addr  = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  evt   = '0;

   logic        gnt, rvalid, irq;
   logic [31:0] rdata;
   logic [3:0]  start;
   logic        gnt_p, rvalid_p, irq_p;
   logic [31:0] rdata_p;
   logic [3:0]  start_p;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [3:0]  m_ctrl, m_ctrl_p, m_status, m_irqen, m_prev;
   logic [31:0] m_scratch;
   int unsigned m_cnt [4];
   logic        exp_rvalid;
   logic [31:0] exp_rdata, exp_rdata_p;

   gpu_ctrl_regs #(.N_CH(4), .START_PULSE(1'b0)) u_dut (
      .clk_i(clk), .rst_i(rst),
      .regs_req_i(req), .regs_we_i(we), .regs_be_i(be),
      .regs_addr_i(addr), .regs_wdata_i(wdata), .regs_gnt_o(gnt),
      .regs_rvalid_o(rvalid), .regs_rdata_o(rdata),
      .int_event_i(evt), .start_o(start), .interrupt_o(irq)
   );

   gpu_ctrl_regs #(.N_CH(4), .START_PULSE(1'b1)) u_dut_p (
      .clk_i(clk), .rst_i(rst),
      .regs_req_i(req), .regs_we_i(we), .regs_be_i(be),
      .regs_addr_i(addr), .regs_wdata_i(wdata), .regs_gnt_o(gnt_p),
      .regs_rvalid_o(rvalid_p), .regs_rdata_o(rdata_p),
      .int_event_i(evt), .start_o(start_p), .interrupt_o(irq_p)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      m_ctrl = '0; m_ctrl_p = '0; m_status = '0; m_irqen = '0; m_prev = '0;
      m_scratch = '0;
      for (int c = 0; c < 4; c++) m_cnt[c] = 0;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      int unsigned w = (a >> 2) & 32'hF;
      if (w == 0) return {28'h0, m_ctrl};
      if (w == 1) return {28'h0, m_status};
      if (w == 2) return {28'h0, m_irqen};
      if (w == 3) return m_scratch;
      if (w >= 8 && w < 12) return m_cnt[w-8];
      return 32'h0;
   endfunction

   // One bus cycle: drive at the falling edge, advance the model at the
   // rising edge, return at the next falling edge ready for sampling.
   task automatic cycle(input bit r, input bit w_e, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] e);
      int unsigned w;
      logic [3:0]  rise;
      logic [31:0] rd;
      req = r; we = w_e; be = b; addr = a; wdata = d; evt = e;
      w    = (a >> 2) & 32'hF;
      rd   = model_read(a);
      rise = e & ~m_prev;
      @(posedge clk);
      exp_rvalid  = r;
      exp_rdata   = (r && !w_e) ? rd : 32'h0;
      exp_rdata_p = (r && !w_e) ? ((w == 0) ? {28'h0, m_ctrl_p} : rd) : 32'h0;
      m_ctrl_p = (r && w_e && w == 0 && b[0]) ? d[3:0] : 4'h0;
      if (r && w_e) begin
         if (w == 0 && b[0]) m_ctrl  = d[3:0];
         if (w == 2 && b[0]) m_irqen = d[3:0];
         if (w == 1 && b[0]) m_status = m_status & ~d[3:0];
         if (w == 3)
            for (int i = 0; i < 4; i++)
               if (b[i]) m_scratch[8*i +: 8] = d[8*i +: 8];
      end
      m_status = m_status | rise;
      for (int c = 0; c < 4; c++) begin
         if (r && w_e && b != 4'h0 && w == 8 + c) m_cnt[c] = 0;
         else if (rise[c] && m_cnt[c] < 65535) m_cnt[c] = m_cnt[c] + 1;
      end
      m_prev = e;
      @(negedge clk);
   endtask

   task automatic test_reset();
      #1;
      checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b exp 0", rvalid); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h exp 0", rdata); end
      checks++; if (start !== 4'h0) begin errors++; $display("FAIL rst_start: got %h exp 0", start); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b exp 0", irq); end
      checks++; if ({gnt_p, rvalid_p, irq_p, start_p, rdata_p} !== '0) begin
         errors++; $display("FAIL rst_pulse_inst: got %b/%b/%b/%h/%h exp all 0", gnt_p, rvalid_p, irq_p, start_p, rdata_p);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      cycle(0, 0, 4'h0, 32'h0, 32'h0, 4'h0);
   endtask

   task automatic test_ctrl();
      cycle(1, 1, 4'hF, 32'h0000_0000, 32'h0000_0005, 4'h0);
      checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL ctrl_gnt: got %b exp 1", gnt); end
      checks++; if (rvalid !== exp_rvalid) begin errors++; $display("FAIL ctrl_wr_rvalid: got %b exp %b", rvalid, exp_rvalid); end
      checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL ctrl_wr_rdata: got %h exp %h", rdata, exp_rdata); end
      checks++; if (start !== m_ctrl) begin errors++; $display("FAIL ctrl_start: got %h exp %h", start, m_ctrl); end
      checks++; if (start_p !== m_ctrl_p) begin errors++; $display("FAIL ctrl_start_pulse_on: got %h exp %h", start_p, m_ctrl_p); end
      cycle(1, 0, 4'hF, 32'hFFFF_FFC0, 32'h0, 4'h0);
      checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL ctrl_rd: got %h exp %h", rdata, exp_rdata); end
      checks++; if (rdata_p !== exp_rdata_p) begin errors++; $display("FAIL ctrl_rd_pulse: got %h exp %h", rdata_p, exp_rdata_p); end
      checks++; if (start_p !== m_ctrl_p) begin errors++; $display("FAIL ctrl_start_pulse_off: got %h exp %h", start_p, m_ctrl_p); end
      checks++; if (start !== m_ctrl) begin errors++; $display("FAIL ctrl_start_level: got %h exp %h", start, m_ctrl); end
      // rewrite of 1 while pulsing holds it for another cycle
      cycle(1, 1, 4'hF, 32'h0, 32'h3, 4'h0);
      cycle(1, 1, 4'hF, 32'h0, 32'h1, 4'h0);
      checks++; if (start_p !== m_ctrl_p) begin errors++; $display("FAIL ctrl_pulse_rewrite: got %h exp %h", start_p, m_ctrl_p); end
      cycle(0, 0, 4'h0, 32'h0, 32'h0, 4'h0);
      checks++; if (rvalid_p !== exp_rvalid || start_p !== m_ctrl_p) begin
         errors++; $display("FAIL ctrl_pulse_idle: got %b/%h exp %b/%h", rvalid_p, start_p, exp_rvalid, m_ctrl_p);
      end
   endtask

   task automatic test_irq();
      cycle(1, 1, 4'hF, 32'h08, 32'h2, 4'h0);
      cycle(0, 0, 4'h0, 32'h0, 32'h0, 4'h2);
      checks++; if (irq !== |(m_status & m_irqen)) begin errors++; $display("FAIL irq_set: got %b exp %b", irq, |(m_status & m_irqen)); end
      cycle(1, 0, 4'hF, 32'h04, 32'h0, 4'h0);
      checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL irq_status: got %h exp %h", rdata, exp_rdata); end
      cycle(1, 0, 4'hF, 32'h24, 32'h0, 4'h0);
      checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL irq_cnt1: got %h exp %h", rdata, exp_rdata); end
      cycle(1, 1, 4'hF, 32'h04, 32'h2, 4'h0);
      checks++; if (irq !== |(m_status & m_irqen)) begin errors++; $display("FAIL irq_clear: got %b exp %b", irq, |(m_status & m_irqen)); end
      cycle(1, 0, 4'hF, 32'h04, 32'h0, 4'h0);
      checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL irq_status_clr: got %h exp %h", rdata, exp_rdata); end
   endtask

   task automatic test_collide();
      cycle(1, 1, 4'h1, 32'h04, 32'h1, 4'h1);
      cycle(1, 0, 4'hF, 32'h04, 32'h0, 4'h0);
      checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL coll_status: got %h exp %h", rdata, exp_rdata); end
      cycle(1, 1, 4'hF, 32'h20, 32'h0, 4'h1);
      cycle(1, 0, 4'hF, 32'h20, 32'h0, 4'h0);
      checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL coll_cnt0: got %h exp %h", rdata, exp_rdata); end
   endtask

   task automatic test_back_to_back();
      cycle(1, 1, 4'hF, 32'h0C, 32'h0, 4'h0);
      cycle(1, 1, 4'h3, 32'h0C, 32'hDEAD_BEEF, 4'h0);
      checks++; if (rvalid !== exp_rvalid) begin errors++; $display("FAIL b2b_rvalid1: got %b exp %b", rvalid, exp_rvalid); end
      cycle(1, 0, 4'hF, 32'h0C, 32'h0, 4'h0);
      checks++; if (rvalid !== exp_rvalid) begin errors++; $display("FAIL b2b_rvalid2: got %b exp %b", rvalid, exp_rvalid); end
      checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL b2b_rdata: got %h exp %h", rdata, exp_rdata); end
      cycle(1, 1, 4'h0, 32'h0C, 32'h1111_1111, 4'h0);
      checks++; if (rvalid !== exp_rvalid) begin errors++; $display("FAIL b2b_be0_rvalid: got %b exp %b", rvalid, exp_rvalid); end
      cycle(1, 0, 4'hF, 32'h0C, 32'h0, 4'h0);
      checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL b2b_be0_rdata: got %h exp %h", rdata, exp_rdata); end
      cycle(1, 1, 4'hF, 32'h3C, 32'hFFFF_FFFF, 4'h0);
      cycle(1, 0, 4'hF, 32'h3C, 32'h0, 4'h0);
      checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL b2b_unmapped: got %h exp %h", rdata, exp_rdata); end
      cycle(0, 0, 4'h0, 32'h0, 32'h0, 4'h0);
      checks++; if (rvalid !== exp_rvalid) begin errors++; $display("FAIL b2b_idle_rvalid: got %b exp %b", rvalid, exp_rvalid); end
   endtask

   task automatic test_random();
      int bad = 0;
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               4'($urandom_range(1, 15)), $urandom(), $urandom(),
               4'($urandom()));
         checks++;
         if (rvalid !== exp_rvalid || rdata !== exp_rdata || start !== m_ctrl ||
             start_p !== m_ctrl_p || irq !== |(m_status & m_irqen)) begin
            errors++;
            if (bad < 5) $display("FAIL rand_cycle%0d: got v=%b d=%h s=%h sp=%h i=%b exp v=%b d=%h s=%h sp=%h i=%b",
                                  i, rvalid, rdata, start, start_p, irq,
                                  exp_rvalid, exp_rdata, m_ctrl, m_ctrl_p, |(m_status & m_irqen));
            bad++;
         end
      end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 70000; i++) begin
         cycle(0, 0, 4'h0, 32'h0, 32'h0, 4'h4);
         cycle(0, 0, 4'h0, 32'h0, 32'h0, 4'h0);
      end
      cycle(1, 0, 4'hF, 32'h28, 32'h0, 4'h0);
      checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL sat_cnt2: got %h exp %h", rdata, exp_rdata); end
      checks++; if (rdata !== 32'h0000_FFFF) begin errors++; $display("FAIL sat_cnt2_max: got %h exp 0000ffff", rdata); end
      cycle(1, 1, 4'hF, 32'h28, 32'h30, 4'h0);
      cycle(1, 0, 4'hF, 32'h28, 32'h0, 4'h0);
      checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL sat_cnt2_clr: got %h exp %h", rdata, exp_rdata); end
   endtask

   task automatic test_reset_mid();
      cycle(1, 1, 4'hF, 32'h00, 32'hF, 4'h1);
      cycle(1, 1, 4'hF, 32'h08, 32'hF, 4'h1);
      cycle(1, 1, 4'hF, 32'h0C, 32'h1234_5678, 4'h1);
      cycle(1, 0, 4'hF, 32'h0C, 32'h0, 4'h1);
      checks++; if (rdata !== exp_rdata || irq !== |(m_status & m_irqen)) begin
         errors++; $display("FAIL rmid_pre: got %h/%b exp %h/%b", rdata, irq, exp_rdata, |(m_status & m_irqen));
      end
      req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h0C; wdata = 32'hFFFF_FFFF;
      #2 rst = 1'b1;
      #1;
      checks++; if ({rvalid, rdata, start, irq} !== '0) begin
         errors++; $display("FAIL rmid_async: got v=%b d=%h s=%h i=%b exp all 0", rvalid, rdata, start, irq);
      end
      model_reset();
      @(posedge clk);
      @(negedge clk);
      req = 1'b0; we = 1'b0;
      rst = 1'b0;
      cycle(0, 0, 4'h0, 32'h0, 32'h0, 4'h1);
      checks++; if (rvalid !== exp_rvalid) begin errors++; $display("FAIL rmid_no_rvalid: got %b exp %b", rvalid, exp_rvalid); end
      cycle(1, 0, 4'hF, 32'h0C, 32'h0, 4'h1);
      checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL rmid_scratch: got %h exp %h", rdata, exp_rdata); end
      cycle(1, 0, 4'hF, 32'h04, 32'h0, 4'h1);
      checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL rmid_status: got %h exp %h", rdata, exp_rdata); end
      cycle(1, 0, 4'hF, 32'h20, 32'h0, 4'h0);
      checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL rmid_cnt0: got %h exp %h", rdata, exp_rdata); end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_ctrl();
      test_irq();
      test_collide();
      test_back_to_back();
      test_random();
      test_saturate();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
